// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL-driven reset sequencer.
package pll_reset_pkg;

  // Sequencer states, in release order.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    PLL_RST   = 3'd1,
    STABLE    = 3'd2,
    DDR_REL   = 3'd3,
    CAL_FAIL  = 3'd4,
    CAP_REL   = 3'd5,
    RUN       = 3'd6
  } seq_state_e;

  // The shared down-counter must hold the longest timeout (calibration).
  localparam int MAX_TIMEOUT_CYCLES = 262144;
  localparam int CNT_W              = $clog2(MAX_TIMEOUT_CYCLES + 1);

  // Saturating increment for the 8-bit event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with synchronous reset for asynchronous flags.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Capture the asynchronous input, then re-register to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Ordered reset release (DDR3 -> capture -> HDMI) driven by PLL lock,
// with PLL re-reset on lock timeout and DDR calibration retry.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int CAL_TIMEOUT_CYCLES  = 262144,
  parameter int STAGE_GAP_CYCLES    = 256
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       ddr_init_done,
  output logic       pll_rst,
  output logic       ddr_rst,
  output logic       cap_rst,
  output logic       hdmi_rst,
  output logic       sys_ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] cal_fail_cnt
);

  logic             lk_s;
  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             cnt_zero_s;
  logic             loss_inc_s;
  logic             cal_inc_s;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Counter value loaded on entry so that a state lasts exactly N cycles.
  function automatic logic [CNT_W-1:0] reload_val(input seq_state_e s);
    case (s)
      WAIT_LOCK: reload_val = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
      PLL_RST:   reload_val = CNT_W'(PLL_RST_CYCLES - 1);
      STABLE:    reload_val = CNT_W'(LOCK_STABLE_CYCLES - 1);
      DDR_REL:   reload_val = CNT_W'(CAL_TIMEOUT_CYCLES - 1);
      CAP_REL:   reload_val = CNT_W'(STAGE_GAP_CYCLES - 1);
      default:   reload_val = {CNT_W{1'b0}};
    endcase
  endfunction

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // Next-state logic; lock loss is checked first so it wins every tie.
  always_comb begin
    state_nxt_s = state_r;
    loss_inc_s  = 1'b0;
    cal_inc_s   = 1'b0;
    case (state_r)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt_s = STABLE;
        end else if (cnt_zero_s) begin
          state_nxt_s = PLL_RST;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      PLL_RST: begin
        if (cnt_zero_s) begin
          state_nxt_s = WAIT_LOCK;
        end else begin
          state_nxt_s = PLL_RST;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (cnt_zero_s) begin
          state_nxt_s = DDR_REL;
        end else begin
          state_nxt_s = STABLE;
        end
      end
      DDR_REL: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          loss_inc_s  = 1'b1;
        end else if (ddr_init_done) begin
          state_nxt_s = CAP_REL;
        end else if (cnt_zero_s) begin
          state_nxt_s = CAL_FAIL;
          cal_inc_s   = 1'b1;
        end else begin
          state_nxt_s = DDR_REL;
        end
      end
      CAL_FAIL: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          loss_inc_s  = 1'b1;
        end else begin
          state_nxt_s = DDR_REL;
        end
      end
      CAP_REL: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          loss_inc_s  = 1'b1;
        end else if (cnt_zero_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CAP_REL;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nxt_s = WAIT_LOCK;
          loss_inc_s  = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
      end
    endcase

    if (state_nxt_s != state_r) begin
      cnt_nxt_s = reload_val(state_nxt_s);
    end else if (cnt_zero_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end
  end

  // State, shared counter, event counters and outputs decoded from next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r       <= WAIT_LOCK;
      cnt_r         <= reload_val(WAIT_LOCK);
      pll_rst       <= 1'b0;
      ddr_rst       <= 1'b1;
      cap_rst       <= 1'b1;
      hdmi_rst      <= 1'b1;
      sys_ready     <= 1'b0;
      lock_loss_cnt <= 8'd0;
      cal_fail_cnt  <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pll_rst   <= (state_nxt_s == PLL_RST);
      ddr_rst   <= !((state_nxt_s == DDR_REL) || (state_nxt_s == CAP_REL) ||
                     (state_nxt_s == RUN));
      cap_rst   <= !((state_nxt_s == CAP_REL) || (state_nxt_s == RUN));
      hdmi_rst  <= (state_nxt_s != RUN);
      sys_ready <= (state_nxt_s == RUN);
      if (loss_inc_s) begin
        lock_loss_cnt <= sat_inc8(lock_loss_cnt);
      end else begin
        lock_loss_cnt <= lock_loss_cnt;
      end
      if (cal_inc_s) begin
        cal_fail_cnt <= sat_inc8(cal_fail_cnt);
      end else begin
        cal_fail_cnt <= cal_fail_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq. Expected waveforms are computed
// from event times (lock rise, calibration done) with plain arithmetic.
module tb_pll_reset_seq;

  localparam int STB   = 8;
  localparam int LTO   = 32;
  localparam int PRC   = 4;
  localparam int CTO   = 20;
  localparam int GAP   = 5;
  localparam int T_REL = STB + 3;  // lock rise -> ddr_rst low

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       ddr_init_done = 1'b0;
  logic       pll_rst, ddr_rst, cap_rst, hdmi_rst, sys_ready;
  logic [7:0] lock_loss_cnt, cal_fail_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int exp_loss = 0;
  int exp_cal  = 0;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (LTO),
    .PLL_RST_CYCLES      (PRC),
    .CAL_TIMEOUT_CYCLES  (CTO),
    .STAGE_GAP_CYCLES    (GAP)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .ddr_init_done (ddr_init_done),
    .pll_rst       (pll_rst),
    .ddr_rst       (ddr_rst),
    .cap_rst       (cap_rst),
    .hdmi_rst      (hdmi_rst),
    .sys_ready     (sys_ready),
    .lock_loss_cnt (lock_loss_cnt),
    .cal_fail_cnt  (cal_fail_cnt)
  );

  always #5 refclk = ~refclk;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_pll, input int e_ddr,
                           input int e_cap, input int e_hdmi, input int e_rdy,
                           input int e_loss, input int e_cal);
    check({tag, ".pll_rst"},   {31'd0, pll_rst},   e_pll);
    check({tag, ".ddr_rst"},   {31'd0, ddr_rst},   e_ddr);
    check({tag, ".cap_rst"},   {31'd0, cap_rst},   e_cap);
    check({tag, ".hdmi_rst"},  {31'd0, hdmi_rst},  e_hdmi);
    check({tag, ".sys_ready"}, {31'd0, sys_ready}, e_rdy);
    check({tag, ".lock_loss"}, {24'd0, lock_loss_cnt}, e_loss);
    check({tag, ".cal_fail"},  {24'd0, cal_fail_cnt},  e_cal);
  endtask

  // Raise lock (after the current edge, unless start_i > 0 means it was
  // raised start_i edges ago) and follow the release sequence. Calibration
  // completes d cycles after DDR release; the DDR window repeats every CTO+1
  // cycles (CTO in DDR_REL, 1 in CAL_FAIL).
  task automatic run_release(input int d, input int start_i, input int stop_i);
    int   p, c_i, j, nf, nmax, last, base;
    logic in_fail;
    p    = d % (CTO + 1);
    c_i  = T_REL + d + ((p == CTO) ? 2 : 1);
    nmax = (d + 1) / (CTO + 1);
    base = exp_cal;
    nf   = 0;
    last = (stop_i > 0) ? stop_i : (c_i + GAP + 2);
    if (start_i == 0) pll_locked = 1'b1;
    for (int i = start_i + 1; i <= last; i++) begin
      tick();
      j  = i - T_REL;
      nf = (j >= CTO) ? ((j - CTO) / (CTO + 1) + 1) : 0;
      if (nf > nmax) nf = nmax;
      in_fail = (j >= CTO) && (((j - CTO) % (CTO + 1)) == 0) && (i < c_i);
      check_all("release", 0, int'((i < T_REL) || in_fail), int'(i < c_i),
                int'(i < c_i + GAP), int'(i >= c_i + GAP), exp_loss, sat8(base + nf));
      if (i == T_REL + d) ddr_init_done = 1'b1;
      if (i == c_i + 1)   ddr_init_done = 1'b0;  // falling in CAP_REL is ignored
    end
    exp_cal = sat8(base + nf);
  endtask

  // From RUN: drop lock permanently, expect all resets 3 cycles later.
  task automatic drop_lock();
    pll_locked = 1'b0;
    tick(); check_all("drop.run1", 0, 0, 0, 0, 1, exp_loss, exp_cal);
    tick(); check_all("drop.run2", 0, 0, 0, 0, 1, exp_loss, exp_cal);
    tick();
    exp_loss = sat8(exp_loss + 1);
    check_all("drop.loss", 0, 1, 1, 1, 0, exp_loss, exp_cal);
    tick(); tick();
    check_all("drop.wait", 0, 1, 1, 1, 0, exp_loss, exp_cal);
  endtask

  initial begin
    int cal_before;

    // Reset values
    tick(); tick(); tick();
    check_all("reset", 0, 1, 1, 1, 0, 0, 0);
    rst = 1'b0;

    // No lock: PLL reset pulse of PRC cycles after LTO cycles, repeating
    for (int i = 1; i <= 80; i++) begin
      tick();
      check_all("pll_timeout", int'((i % (LTO + PRC)) >= LTO), 1, 1, 1, 0, exp_loss, exp_cal);
    end

    // Nominal release: DDR at +11, capture at +21, HDMI at +26
    run_release(9, 0, 0);

    // One-cycle lock drop in RUN, then lock returns
    pll_locked = 1'b0;
    tick(); check_all("blip.run1", 0, 0, 0, 0, 1, exp_loss, exp_cal);
    pll_locked = 1'b1;
    tick(); check_all("blip.run2", 0, 0, 0, 0, 1, exp_loss, exp_cal);
    tick();
    exp_loss = sat8(exp_loss + 1);
    check_all("blip.loss", 0, 1, 1, 1, 0, exp_loss, exp_cal);
    run_release($urandom_range(70, 0), 2, 0);

    // Calibration never done for three timeouts
    drop_lock();
    cal_before = exp_cal;
    run_release(70, 0, 0);
    check("cal_three", {24'd0, cal_fail_cnt}, cal_before + 3);

    // Lock drop during STABLE: back to WAIT_LOCK, not a loss
    drop_lock();
    run_release(50, 0, 5);
    pll_locked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("stable_drop", 0, 1, 1, 1, 0, exp_loss, exp_cal);
    end
    run_release($urandom_range(70, 0), 0, 0);

    // Lock loss in the same cycle calibration completes: loss wins
    drop_lock();
    run_release(50, 0, 14);
    pll_locked = 1'b0;
    tick(); check_all("tie.ddr1", 0, 0, 1, 1, 0, exp_loss, exp_cal);
    tick(); check_all("tie.ddr2", 0, 0, 1, 1, 0, exp_loss, exp_cal);
    ddr_init_done = 1'b1;
    tick();
    exp_loss = sat8(exp_loss + 1);
    check_all("tie.loss", 0, 1, 1, 1, 0, exp_loss, exp_cal);
    ddr_init_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("tie.wait", 0, 1, 1, 1, 0, exp_loss, exp_cal);
    end
    run_release($urandom_range(70, 0), 0, 0);

    // Randomized calibration delays
    for (int k = 0; k < 4; k++) begin
      drop_lock();
      run_release($urandom_range(70, 0), 0, 0);
    end

    // Synchronous reset while in CAP_REL, then a fresh sequence
    drop_lock();
    run_release(0, 0, 14);
    rst = 1'b1;
    tick();
    exp_loss = 0;
    exp_cal  = 0;
    check_all("srst", 0, 1, 1, 1, 0, 0, 0);
    rst = 1'b0;
    run_release(3, 0, 0);

    // Lock-loss counter saturation
    for (int n = 0; n < 256; n++) begin
      drop_lock();
      run_release(0, 0, 0);
    end
    check("loss_sat", {24'd0, lock_loss_cnt}, 255);

    // Calibration-failure counter saturation
    drop_lock();
    run_release(5400, 0, 0);
    check("cal_sat", {24'd0, cal_fail_cnt}, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer clocked by the 200 MHz output of `sample_pll`. Consumes the PLL `locked` flag and the DDR3 controller calibration-done flag, and releases the reset domains in order: DDR3 controller, then CMOS capture, then HDMI output. On any loss of lock it re-asserts every downstream reset and restarts the sequence. It also pulses the PLL's own reset if lock is not achieved within a timeout.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive synced-locked cycles required before the first release.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles in WAIT_LOCK before a PLL reset pulse is issued.
- `PLL_RST_CYCLES`, 16: width of the `pll_rst` pulse.
- `CAL_TIMEOUT_CYCLES`, 262144: cycles allowed for `ddr_init_done` after DDR release.
- `STAGE_GAP_CYCLES`, 256: delay between the CAP and HDMI releases.
- `refclk`, input, 1: 200 MHz clock from the PLL; the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `pll_locked`, input, 1: asynchronous PLL lock flag; synchronised internally.
- `ddr_init_done`, input, 1: DDR3 calibration complete. Synchronous to `refclk`, level.
- `pll_rst`, output, 1: reset request to the PLL (active high).
- `ddr_rst`, output, 1: DDR3 controller reset (active high).
- `cap_rst`, output, 1: CMOS capture reset (active high).
- `hdmi_rst`, output, 1: HDMI pipeline reset (active high).
- `sys_ready`, output, 1: high only in RUN.
- `lock_loss_cnt`, output, 8: count of lock losses after the first lock; saturates at 255.
- `cal_fail_cnt`, output, 8: count of calibration timeouts; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lk`. All decisions use `lk`.
- One shared down-counter serves every state. It is reloaded on each state entry.
- States and transitions:
  - WAIT_LOCK: all domain resets high.
    - `lk` → STABLE.
    - Counter expires → PLL_RST.
  - PLL_RST: `pll_rst` high for `PLL_RST_CYCLES`, then → WAIT_LOCK with the timeout reloaded.
  - STABLE: `lk` must stay high for `LOCK_STABLE_CYCLES`; then → DDR_REL. A drop in `lk` → WAIT_LOCK with no count increment, because this is not yet a loss.
  - DDR_REL: `ddr_rst` low.
    - `ddr_init_done` → CAP_REL.
    - Counter expires → CAL_FAIL.
  - CAL_FAIL: `ddr_rst` high for one cycle, `cal_fail_cnt`++, then → DDR_REL (retry with a fresh timeout).
  - CAP_REL: `ddr_rst` and `cap_rst` low. Wait `STAGE_GAP_CYCLES`, then → RUN.
  - RUN: all resets low, `sys_ready` high.
- Lock loss: `lk` low in DDR_REL, CAL_FAIL, CAP_REL or RUN → WAIT_LOCK. On that transition `lock_loss_cnt`++ and all resets go high.
- `ddr_init_done` falling in CAP_REL or RUN is ignored.
- Both counters saturate at 8'hFF.

## Timing
- Reset values while `rst` is high:
  - `ddr_rst`, `cap_rst`, `hdmi_rst` = 1.
  - `pll_rst`, `sys_ready` = 0.
  - Both count outputs = 0.
  - State = WAIT_LOCK.
  - Synchroniser flops = 0.
- Every output is a register output.
- A `pll_locked` edge reaches `lk` 2 cycles later. The FSM reacts on the following edge.
- First release: `pll_locked` rising to `ddr_rst` falling = 2 + 1 + `LOCK_STABLE_CYCLES` cycles.
- `ddr_init_done` sampled high → `cap_rst` low on the next edge.
- `cap_rst` low → `hdmi_rst` low and `sys_ready` high after exactly `STAGE_GAP_CYCLES` cycles.
- Lock drop to all resets asserted: 3 cycles after the `pll_locked` edge.
- Simultaneous events: lock loss takes priority over `ddr_init_done` and over every counter expiry in the same cycle.
- `rst` asserted mid-sequence: every output takes its reset value on the next edge. Counters clear.

## Structure
- Shared package `pll_reset_pkg`: state enum (WAIT_LOCK, PLL_RST, STABLE, DDR_REL, CAL_FAIL, CAP_REL, RUN) and the counter width constant (sized for the largest timeout parameter).
- Sub-module `sync2`: a 2-flop synchroniser with synchronous reset, also reusable for other CDC flags.
- The FSM, the shared counter and the event counters sit in the top module.

## Test plan
Bench parameters: STABLE = 8, LOCK_TIMEOUT = 32, PLL_RST = 4, CAL_TIMEOUT = 20, GAP = 5.
- `pll_locked` rises at cycle 10; `ddr_init_done` rises at cycle 30 → `ddr_rst` falls at cycle 21, `cap_rst` falls at cycle 31, `hdmi_rst` falls and `sys_ready` rises at cycle 36.
- `pll_locked` held low → `pll_rst` high for 4 cycles after 32 cycles in WAIT_LOCK. This repeats every 36 cycles, and all domain resets stay high throughout.
- `ddr_init_done` never asserted → `ddr_rst` pulses high for 1 cycle every 21 cycles, and `cal_fail_cnt` reads 3 after three timeouts.
- In RUN, drop `pll_locked` for 1 cycle → all resets high 3 cycles later and `lock_loss_cnt` = 1. Re-raise `pll_locked` → the sequence repeats with the same latencies.
- `lk` falls in the same cycle that `ddr_init_done` rises in DDR_REL → WAIT_LOCK is entered, `cap_rst` stays high, and `lock_loss_cnt` increments.
- Assert `rst` for 1 cycle in CAP_REL → all outputs return to reset values on the next edge, and the sequence restarts from WAIT_LOCK.
